hmac_pad_seq: RTL and testbench

//  Parametrised HMAC pad/finalisation sequencer for the SHA-1/SHA-256 HMAC path.
//  - Latches a 512-bit key and emits three 512-bit blocks to the SHA core:

---
 rtl/hmac_pkg.sv | 25 ++
 rtl/hmac_final_fmt.sv | 23 ++
 rtl/hmac_pad_seq.sv | 126 ++++++++++++
 tb/tb_hmac_pad_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hmac_pkg.sv
// Shared constants and state type for the HMAC pad/finalisation sequencer.
package hmac_pkg;

   localparam logic [31:0] IPAD_WORD   = 32'h36363636;
   localparam logic [31:0] OPAD_WORD   = 32'h5c5c5c5c;
   localparam logic [31:0] SHA_PAD_BIT = 32'h80000000;
   localparam int          SHA_BLOCK_W = 512;
   localparam int          SHA_LEN_W   = 64;
   localparam int          SHA_WORDS   = SHA_BLOCK_W / 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      IPAD     = 3'd1,
      WAIT_DIG = 3'd2,
      OPAD     = 3'd3,
      FINAL    = 3'd4
   } hmac_seq_state_t;

   // XOR every 32-bit word of a block with the same pad pattern.
   function automatic logic [SHA_BLOCK_W-1:0] pad_xor(input logic [SHA_BLOCK_W-1:0] blk,
                                                      input logic [31:0]            pattern);
      return blk ^ {SHA_WORDS{pattern}};
   endfunction

endpackage

// File: rtl/hmac_final_fmt.sv
// Builds the outer-hash final block: inner digest, SHA padding bit, zero fill, 64-bit bit length.
module hmac_final_fmt
   import hmac_pkg::*;
#(
   parameter int DIGEST_W = 160
) (
   input  logic [DIGEST_W-1:0]    digest,
   output logic [SHA_BLOCK_W-1:0] blk
);

   localparam int                   DIG_WORDS = DIGEST_W / 32;
   // Outer message is one key block plus the inner digest.
   localparam logic [SHA_LEN_W-1:0] MSG_BITS  = SHA_LEN_W'(SHA_BLOCK_W + DIGEST_W);

   always_comb begin
      blk                              = '0;
      blk[DIGEST_W-1:0]                = digest;
      blk[32*DIG_WORDS +: 32]          = SHA_PAD_BIT;
      blk[32*(SHA_WORDS-2) +: 32]      = MSG_BITS[63:32];
      blk[32*(SHA_WORDS-1) +: 32]      = MSG_BITS[31:0];
   end

endmodule

// File: rtl/hmac_pad_seq.sv
// HMAC sequencer: emits ipad, opad and final outer blocks to the SHA core over valid/ready.
module hmac_pad_seq
   import hmac_pkg::*;
#(
   parameter int DIGEST_W = 160,
   parameter int BLOCK_W  = 512
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic [BLOCK_W-1:0]  key,
   input  logic                digest_valid,
   output logic                digest_ready,
   input  logic [DIGEST_W-1:0] digest_in,
   output logic                blk_valid,
   input  logic                blk_ready,
   output logic [BLOCK_W-1:0]  blk_data,
   output logic                blk_first,
   output logic                blk_last,
   output logic                hmac_done
);

   if ((DIGEST_W % 32) != 0 || DIGEST_W < 160 || DIGEST_W > 256) begin : g_bad_digest_w
      $error("hmac_pad_seq: DIGEST_W must be a multiple of 32 in 160..256");
   end
   if (BLOCK_W != SHA_BLOCK_W) begin : g_bad_block_w
      $error("hmac_pad_seq: BLOCK_W must equal SHA_BLOCK_W");
   end

   hmac_seq_state_t      state, state_next;
   logic [BLOCK_W-1:0]   key_q;
   logic [DIGEST_W-1:0]  digest_q;
   logic [BLOCK_W-1:0]   final_blk;
   logic                 key_fire, digest_fire, final_fire;

   // clr suppresses every handshake so an aborted sequence leaves no side effects.
   assign key_fire    = key_valid    & key_ready    & ~clr;
   assign digest_fire = digest_valid & digest_ready & ~clr;
   assign final_fire  = (state == FINAL) & blk_ready & ~clr;

   hmac_final_fmt #(
      .DIGEST_W (DIGEST_W)
   ) u_final_fmt (
      .digest (digest_q),
      .blk    (final_blk)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (clr) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:     if (key_valid)    state_next = IPAD;
            IPAD:     if (blk_ready)    state_next = WAIT_DIG;
            WAIT_DIG: if (digest_valid) state_next = OPAD;
            OPAD:     if (blk_ready)    state_next = FINAL;
            FINAL:    if (blk_ready)    state_next = IDLE;
            default:                    state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      key_ready    = 1'b0;
      digest_ready = 1'b0;
      blk_valid    = 1'b0;
      blk_first    = 1'b0;
      blk_last     = 1'b0;
      blk_data     = '0;
      case (state)
         IDLE: begin
            key_ready = 1'b1;
         end
         IPAD: begin
            blk_valid = 1'b1;
            blk_first = 1'b1;
            blk_data  = pad_xor(key_q, IPAD_WORD);
         end
         WAIT_DIG: begin
            digest_ready = 1'b1;
         end
         OPAD: begin
            blk_valid = 1'b1;
            blk_first = 1'b1;
            blk_data  = pad_xor(key_q, OPAD_WORD);
         end
         FINAL: begin
            blk_valid = 1'b1;
            blk_last  = 1'b1;
            blk_data  = final_blk;
         end
         default: begin
            key_ready = 1'b0;
         end
      endcase
   end

   // Key and digest only move on their own handshake, so block data is stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q     <= '0;
         digest_q  <= '0;
         hmac_done <= 1'b0;
      end else begin
         if (key_fire) begin
            key_q <= key;
         end
         if (digest_fire) begin
            digest_q <= digest_in;
         end
         hmac_done <= final_fire;
      end
   end

endmodule

// File: tb/tb_hmac_pad_seq.sv
// Randomised self-checking bench: SHA-1 and SHA-256 sequencers driven in lockstep against a block model.
module tb_hmac_pad_seq;

   logic         clk          = 1'b0;
   logic         rst_n        = 1'b0;
   logic         clr          = 1'b0;
   logic         key_valid    = 1'b0;
   logic         digest_valid = 1'b0;
   logic         blk_ready    = 1'b1;
   logic [511:0] key          = '0;
   logic [255:0] digest_in    = '0;

   logic         s_key_ready, s_digest_ready, s_blk_valid, s_blk_first, s_blk_last, s_hmac_done;
   logic         l_key_ready, l_digest_ready, l_blk_valid, l_blk_first, l_blk_last, l_hmac_done;
   logic [511:0] s_blk_data, l_blk_data;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   hmac_pad_seq #(.DIGEST_W(160), .BLOCK_W(512)) dut_sha1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .key_valid    (key_valid),
      .key_ready    (s_key_ready),
      .key          (key),
      .digest_valid (digest_valid),
      .digest_ready (s_digest_ready),
      .digest_in    (digest_in[159:0]),
      .blk_valid    (s_blk_valid),
      .blk_ready    (blk_ready),
      .blk_data     (s_blk_data),
      .blk_first    (s_blk_first),
      .blk_last     (s_blk_last),
      .hmac_done    (s_hmac_done)
   );

   hmac_pad_seq #(.DIGEST_W(256), .BLOCK_W(512)) dut_sha256 (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .key_valid    (key_valid),
      .key_ready    (l_key_ready),
      .key          (key),
      .digest_valid (digest_valid),
      .digest_ready (l_digest_ready),
      .digest_in    (digest_in),
      .blk_valid    (l_blk_valid),
      .blk_ready    (blk_ready),
      .blk_data     (l_blk_data),
      .blk_first    (l_blk_first),
      .blk_last     (l_blk_last),
      .hmac_done    (l_hmac_done)
   );

   // Reference blocks built word by word from the HMAC/SHA padding rules.
   function automatic logic [511:0] pad_block(input logic [511:0] k, input logic [31:0] pattern);
      logic [511:0] b;
      for (int w = 0; w < 16; w++) b[32*w +: 32] = k[32*w +: 32] ^ pattern;
      return b;
   endfunction

   function automatic logic [511:0] final_block(input logic [255:0] dig, input int digest_bits);
      logic [511:0] b;
      logic [31:0]  word;
      int           n_words;
      n_words = digest_bits / 32;
      for (int w = 0; w < 16; w++) begin
         if (w < n_words)       word = dig[32*w +: 32];
         else if (w == n_words) word = 32'h80000000;
         else if (w == 15)      word = 32'(512 + digest_bits);
         else                   word = 32'h0;
         b[32*w +: 32] = word;
      end
      return b;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   task automatic check_output(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Control vector order: key_ready, digest_ready, blk_valid, blk_first, blk_last, hmac_done.
   task automatic check_ctl(input string tag, input logic [5:0] expected);
      check_output({tag, "/ctl160"}, 512'({s_key_ready, s_digest_ready, s_blk_valid,
                                           s_blk_first, s_blk_last, s_hmac_done}), 512'(expected));
      check_output({tag, "/ctl256"}, 512'({l_key_ready, l_digest_ready, l_blk_valid,
                                           l_blk_first, l_blk_last, l_hmac_done}), 512'(expected));
   endtask

   task automatic check_block(input string tag, input logic [511:0] exp_s, input logic [511:0] exp_l,
                              input logic first, input logic last);
      check_ctl(tag, {3'b001, first, last, 1'b0});
      check_output({tag, "/data160"}, s_blk_data, exp_s);
      check_output({tag, "/data256"}, l_blk_data, exp_l);
   endtask

   task automatic check_quiet(input string tag);
      check_ctl(tag, 6'b100000);
      check_output({tag, "/data160"}, s_blk_data, '0);
      check_output({tag, "/data256"}, l_blk_data, '0);
   endtask

   // Drives key handshake and the ipad block; leaves both sequencers waiting for a digest.
   task automatic apply_key(input logic [511:0] k, input int stall_ipad);
      logic [511:0] exp_ipad;
      exp_ipad = pad_block(k, 32'h36363636);
      check_ctl("idle", 6'b100000);
      key = k; key_valid = 1'b1; blk_ready = 1'b1;
      step();
      key_valid = 1'b0; key = rand512();
      blk_ready = (stall_ipad == 0);
      for (int i = 0; i < stall_ipad; i++) begin
         check_block("ipad_stall", exp_ipad, exp_ipad, 1'b1, 1'b0);
         key_valid = 1'($urandom_range(1));
         step();
      end
      key_valid = 1'b0; blk_ready = 1'b1;
      check_block("ipad", exp_ipad, exp_ipad, 1'b1, 1'b0);
      step();
   endtask

   task automatic apply_stimulus(input logic [511:0] k, input logic [255:0] d, input int stall_ipad,
                                 input int stall_final, input int wait_dig);
      logic [511:0] exp_s, exp_l;
      apply_key(k, stall_ipad);
      for (int i = 0; i < wait_dig; i++) begin
         check_ctl("wait_dig", 6'b010000);
         step();
      end
      check_ctl("wait_dig", 6'b010000);
      digest_in = d; digest_valid = 1'b1;
      step();
      digest_valid = 1'b0; digest_in = rand256();
      exp_s = pad_block(k, 32'h5c5c5c5c);
      check_block("opad", exp_s, exp_s, 1'b1, 1'b0);
      step();
      exp_s = final_block({96'h0, d[159:0]}, 160);
      exp_l = final_block(d, 256);
      blk_ready = (stall_final == 0);
      for (int i = 0; i < stall_final; i++) begin
         check_block("final_stall", exp_s, exp_l, 1'b0, 1'b1);
         step();
      end
      blk_ready = 1'b1;
      check_block("final", exp_s, exp_l, 1'b0, 1'b1);
      step();
      check_ctl("done", 6'b100001);
      step();
      check_quiet("after_done");
   endtask

   initial begin
      logic [255:0] d_inc;
      logic [511:0] exp_s;

      // Reset state, then ten idle cycles.
      repeat (2) @(posedge clk);
      #1;
      check_quiet("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_quiet("idle_hold");
      end

      // Zero key, incrementing digest words, no backpressure.
      for (int w = 0; w < 8; w++) d_inc[32*w +: 32] = 32'(w + 1);
      apply_stimulus('0, d_inc, 0, 0, 0);

      // Backpressure in ipad and final.
      apply_stimulus(rand512(), rand256(), 5, 5, 2);

      // clr in WAIT_DIG beats a same-cycle digest handshake.
      apply_key(rand512(), 0);
      check_ctl("pre_clr", 6'b010000);
      clr = 1'b1; digest_valid = 1'b1; digest_in = rand256();
      step();
      clr = 1'b0; digest_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_quiet("after_clr");
         step();
      end
      apply_stimulus(rand512(), rand256(), 1, 0, 1);

      // Asynchronous reset while the final block is stalled.
      d_inc = rand256();
      apply_key(rand512(), 0);
      digest_in = d_inc; digest_valid = 1'b1;
      step();
      digest_valid = 1'b0;
      step();
      blk_ready = 1'b0;
      exp_s = final_block({96'h0, d_inc[159:0]}, 160);
      check_block("final_pre_rst", exp_s, final_block(d_inc, 256), 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_quiet("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      blk_ready = 1'b1;
      step();
      check_quiet("post_rst");
      apply_stimulus(rand512(), rand256(), 0, 2, 0);

      // Randomised transactions.
      for (int n = 0; n < 8; n++) begin
         apply_stimulus(rand512(), rand256(), $urandom_range(3), $urandom_range(3), $urandom_range(2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
